mask_frame_streamer: RTL

Frame-rate transmitter that feeds the connected-components labeller. It reads a stored 1-bit mask frame from a synchronous BRAM read port in row-major order and emits the pixel stream (x, y, mask, valid, new_frame) the labeller consumes. It waits for the labeller to be idle before starting a frame, and honours downstream back-pressure through a small skid FIFO that absorbs BRAM read latency.

---
 rtl/mask_frame_streamer_if.sv | 20 ++
 rtl/mask_frame_streamer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mask_frame_streamer_if.sv
// Pixel stream bundle between the mask streamer and the connected-components labeller.
// Carries start-of-frame, beat handshake, pixel coordinates and mask bit.
interface mask_frame_streamer_if;
  logic        new_frame_out;
  logic        valid_out;
  logic        ready_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        mask_out;

  modport master (
    output new_frame_out, valid_out, x_out, y_out, mask_out,
    input  ready_in
  );

  modport slave (
    input  new_frame_out, valid_out, x_out, y_out, mask_out,
    output ready_in
  );
endinterface

// File: rtl/mask_frame_streamer.sv
// Streams a stored 1-bit mask frame from BRAM to the labeller in row-major order.
// Optional MASK_COUNT_EN adds ones_count_out, a per-frame count of set pixels.
module mask_frame_streamer #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 180,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = $clog2(WIDTH*HEIGHT),
  localparam int CW        = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              cc_busy_in,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic              rd_data_in,
  mask_frame_streamer_if.master px,
  output logic              busy_out,
`ifdef MASK_COUNT_EN
  output logic [CW-1:0]     ones_count_out,
`endif
  output logic              done_out
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FIFO_DEPTH+1);
  localparam logic [10:0]   X_LAST = 11'(WIDTH-1);
  localparam logic [9:0]    Y_LAST = 10'(HEIGHT-1);
  localparam logic [PW-1:0] P_LAST = PW'(FIFO_DEPTH-1);

  typedef enum logic [2:0] {
    IDLE, WAIT_CC, SOF, STREAM, DRAIN, DONE
  } state_t;

  state_t state;

  logic [10:0]       x_cnt, rd_x;
  logic [9:0]        y_cnt, rd_y;
  logic [ADDR_W-1:0] addr_cnt;

  logic [RD_LATENCY-1:0] pv;
  logic [10:0] ptx [RD_LATENCY];
  logic [9:0]  pty [RD_LATENCY];

  logic [10:0] fx [FIFO_DEPTH];
  logic [9:0]  fy [FIFO_DEPTH];
  logic        fm [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [FW-1:0] fcnt;

  logic [7:0] inflight, occ;
  logic push, pop, issue, last, drained;

  always_comb begin
    inflight = 8'(rd_en_out);
    for (int i = 0; i < RD_LATENCY; i++)
      inflight = inflight + 8'(pv[i]);
    push    = pv[RD_LATENCY-1];
    pop     = (fcnt != '0) && px.ready_in;
    // A pop this cycle frees a slot, so the next read can be issued now.
    occ     = inflight + 8'(fcnt) - 8'(pop);
    issue   = (state == STREAM) && (occ < 8'(FIFO_DEPTH));
    last    = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    drained = (inflight == 8'd0) &&
              ((fcnt == '0) || ((fcnt == FW'(1)) && pop));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      x_cnt         <= '0;
      y_cnt         <= '0;
      addr_cnt      <= '0;
      rd_x          <= '0;
      rd_y          <= '0;
      rd_en_out     <= 1'b0;
      rd_addr_out   <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      px.new_frame_out <= 1'b0;
    end else begin
      rd_en_out        <= 1'b0;
      done_out         <= 1'b0;
      px.new_frame_out <= 1'b0;
      unique case (state)
        IDLE: if (start_in) begin
          state    <= WAIT_CC;
          busy_out <= 1'b1;
        end
        WAIT_CC: if (!cc_busy_in) begin
          state            <= SOF;
          px.new_frame_out <= 1'b1;
        end
        SOF: begin
          x_cnt    <= '0;
          y_cnt    <= '0;
          addr_cnt <= '0;
          state    <= STREAM;
        end
        STREAM: if (issue) begin
          rd_en_out   <= 1'b1;
          rd_addr_out <= addr_cnt;
          rd_x        <= x_cnt;
          rd_y        <= y_cnt;
          addr_cnt    <= addr_cnt + ADDR_W'(1);
          if (last) begin
            state <= DRAIN;
          end else if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + 10'd1;
          end else begin
            x_cnt <= x_cnt + 11'd1;
          end
        end
        DRAIN: if (drained) begin
          state    <= DONE;
          done_out <= 1'b1;
          busy_out <= 1'b0;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pv   <= '0;
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      pv[0] <= rd_en_out;
      for (int i = 1; i < RD_LATENCY; i++)
        pv[i] <= pv[i-1];
      if (push)
        wp <= (wp == P_LAST) ? '0 : wp + PW'(1);
      if (pop)
        rp <= (rp == P_LAST) ? '0 : rp + PW'(1);
      case ({push, pop})
        2'b10:   fcnt <= fcnt + FW'(1);
        2'b01:   fcnt <= fcnt - FW'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

  // Tag pipe and FIFO storage need no reset; valid bits and pointers gate them.
  always_ff @(posedge clk_in) begin
    ptx[0] <= rd_x;
    pty[0] <= rd_y;
    for (int i = 1; i < RD_LATENCY; i++) begin
      ptx[i] <= ptx[i-1];
      pty[i] <= pty[i-1];
    end
    if (push) begin
      fx[wp] <= ptx[RD_LATENCY-1];
      fy[wp] <= pty[RD_LATENCY-1];
      fm[wp] <= rd_data_in;
    end
  end

  assign px.valid_out = (fcnt != '0);
  assign px.x_out     = fx[rp];
  assign px.y_out     = fy[rp];
  assign px.mask_out  = fm[rp];

`ifdef MASK_COUNT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      ones_count_out <= '0;
    else if (state == SOF)
      ones_count_out <= '0;
    else if (pop && fm[rp])
      ones_count_out <= ones_count_out + CW'(1);
  end
`endif

endmodule
